// File: rtl/ysyx_220066_mul_ctrl.sv
// ysyx_220066_mul_ctrl
// Issue/collect controller that sits in front of the Booth/Wallace multiplier.
// It accepts one multiply, holds the operands and signedness stable for the
// datapath latency, then picks and extends the right half of the 128-bit
// product and returns it to writeback.

module ysyx_220066_mul_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_funct3,
    input  logic         in_word,
    input  logic [63:0]  in_rs1,
    input  logic [63:0]  in_rs2,
    output logic [63:0]  mul_rs1,
    output logic [63:0]  mul_rs2,
    output logic [1:0]   mul_sign,
    input  logic [127:0] mul_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // How the finished product is turned into the 64-bit result.
    typedef enum logic [1:0] {
        SEL_LO   = 2'd0,
        SEL_HI   = 2'd1,
        SEL_WORD = 2'd2,
        SEL_ZERO = 2'd3
    } sel_t;

    state_t          state;
    state_t          next_state;
    logic [CNT_W-1:0] cnt;
    sel_t            sel;

    sel_t            dec_sel;
    logic [1:0]      dec_sign;
    logic [63:0]     dec_rs1;
    logic [63:0]     dec_rs2;

    logic            accept;
    logic            last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = (state == IDLE) && in_valid && !flush;
    assign last      = (state == BUSY) && (cnt == CNT_LAST);

    // Decode funct3/word into signedness, result selection and operand form.
    // Illegal encodings still run through the datapath but yield zero.
    always_comb begin
        dec_sel  = SEL_ZERO;
        dec_sign = 2'b00;
        dec_rs1  = in_rs1;
        dec_rs2  = in_rs2;
        if (in_word) begin
            dec_rs1 = {{32{in_rs1[31]}}, in_rs1[31:0]};
            dec_rs2 = {{32{in_rs2[31]}}, in_rs2[31:0]};
            if (in_funct3 == 3'd0) begin
                dec_sel  = SEL_WORD;
                dec_sign = 2'b11;
            end
        end else begin
            case (in_funct3)
                3'd0: begin
                    dec_sel  = SEL_LO;
                    dec_sign = 2'b11;
                end
                3'd1: begin
                    dec_sel  = SEL_HI;
                    dec_sign = 2'b11;
                end
                3'd2: begin
                    dec_sel  = SEL_HI;
                    dec_sign = 2'b10;
                end
                3'd3: begin
                    dec_sel  = SEL_HI;
                    dec_sign = 2'b00;
                end
                default: begin
                    dec_sel  = SEL_ZERO;
                    dec_sign = 2'b00;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  next_state = BUSY;
                BUSY:    if (last)      next_state = DONE;
                DONE:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Latency counter: restarts on accept and counts the busy cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush || accept || last) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand registers change only on accept, so the datapath never sees a mid-op change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_rs1  <= '0;
            mul_rs2  <= '0;
            mul_sign <= 2'b00;
            sel      <= SEL_LO;
        end else if (accept) begin
            mul_rs1  <= dec_rs1;
            mul_rs2  <= dec_rs2;
            mul_sign <= dec_sign;
            sel      <= dec_sel;
        end
    end

    // Capture the selected result on the final busy cycle and hold it through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (last && !flush) begin
            case (sel)
                SEL_LO:   out_data <= mul_result[63:0];
                SEL_HI:   out_data <= mul_result[127:64];
                SEL_WORD: out_data <= {{32{mul_result[31]}}, mul_result[31:0]};
                default:  out_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mul_ctrl.sv
// Testbench for ysyx_220066_mul_ctrl.
// A behavioural multiplier drives mul_result from the registered operands;
// expected results are queued when an op is issued and compared on out_valid.

module tb_ysyx_220066_mul_ctrl;

    localparam int MUL_LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_funct3;
    logic         in_word;
    logic [63:0]  in_rs1;
    logic [63:0]  in_rs2;
    logic [63:0]  mul_rs1;
    logic [63:0]  mul_rs2;
    logic [1:0]   mul_sign;
    logic [127:0] mul_result;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    int pass_count = 0;
    int total_count = 0;
    logic [63:0] exp_q[$];

    ysyx_220066_mul_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_word    (in_word),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .mul_rs1    (mul_rs1),
        .mul_rs2    (mul_rs2),
        .mul_sign   (mul_sign),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: full 128-bit product with per-operand signedness.
    logic [127:0] ext_a;
    logic [127:0] ext_b;
    always_comb begin
        ext_a = mul_sign[1] ? {{64{mul_rs1[63]}}, mul_rs1} : {64'b0, mul_rs1};
        ext_b = mul_sign[0] ? {{64{mul_rs2[63]}}, mul_rs2} : {64'b0, mul_rs2};
        mul_result = ext_a * ext_b;
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one op: wait for in_ready, hold in_valid over one posedge, optionally queue its result.
    task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] expv, input bit push);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("issue_ready", {127'b0, in_ready}, 128'd1);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_word   = w;
        in_rs1    = a;
        in_rs2    = b;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        in_valid  = 1'b0;
        in_rs1    = $urandom();
        in_rs2    = $urandom();
    endtask

    // Wait for a result, check latency and data, hold it for 'hold' cycles, then accept it.
    task automatic checkOutput(input string tag, input int hold);
        int waited = 0;
        logic [63:0] expv;
        logic [63:0] first;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, {127'b0, out_valid}, 128'd1);
        if (out_valid) begin
            check({tag, "_latency"}, 128'(waited), 128'(MUL_LAT));
            if (exp_q.size() == 0) begin
                check({tag, "_queue"}, 128'd0, 128'd1);
                expv = '0;
            end else begin
                expv = exp_q.pop_front();
            end
            check({tag, "_data"}, {64'b0, out_data}, {64'b0, expv});
            first = out_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, {127'b0, out_valid}, 128'd1);
                check({tag, "_hold_data"}, {64'b0, out_data}, {64'b0, first});
                check({tag, "_hold_noready"}, {127'b0, in_ready}, 128'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_ret_ready"}, {127'b0, in_ready}, 128'd1);
            check({tag, "_ret_valid"}, {127'b0, out_valid}, 128'd0);
        end
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bit seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_word   = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", {127'b0, in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_data", {64'b0, out_data}, 128'd0);
        check("rst_mul_rs1", {64'b0, mul_rs1}, 128'd0);
        check("rst_mul_sign", {126'b0, mul_sign}, 128'd0);

        // MUL 3*5 with a 3-cycle hold
        applyStimulus(3'd0, 1'b0, 64'd3, 64'd5, 64'h0F, 1'b1);
        checkOutput("mul", 3);

        // MULHU and MULH of all-ones
        applyStimulus(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        checkOutput("mulhu", 0);
        applyStimulus(3'd1, 1'b0, '1, '1, 64'h0, 1'b1);
        checkOutput("mulh", 0);

        // MULHSU -1 * 2, signedness visible while busy
        applyStimulus(3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("mulhsu_sign", {126'b0, mul_sign}, 128'b10);
        checkOutput("mulhsu", 0);

        // MULW with garbage upper bits
        applyStimulus(3'd0, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
                      64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check("mulw_rs1", {64'b0, mul_rs1}, 128'h7FFF_FFFF);
        check("mulw_rs2", {64'b0, mul_rs2}, 128'h2);
        checkOutput("mulw", 0);

        // Illegal encodings return zero
        applyStimulus(3'd5, 1'b0, 64'd3, 64'd5, 64'h0, 1'b1);
        checkOutput("illegal_f3", 0);
        applyStimulus(3'd1, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0, 1'b1);
        checkOutput("illegal_word", 0);

        // Flush in BUSY with cnt=0; a same-cycle request must be ignored
        applyStimulus(3'd0, 1'b0, 64'd7, 64'd9, 64'h0, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_funct3 = 3'd0;
        in_rs1    = 64'd11;
        in_rs2    = 64'd13;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", {127'b0, in_ready}, 128'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", {127'b0, seen}, 128'd0);
        applyStimulus(3'd0, 1'b0, 64'd2, 64'd2, 64'd4, 1'b1);
        checkOutput("post_flush", 0);

        // Asynchronous reset mid-BUSY, off the clock edge
        applyStimulus(3'd0, 1'b0, 64'd6, 64'd7, 64'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {127'b0, out_valid}, 128'd0);
        check("arst_mul_rs1", {64'b0, mul_rs1}, 128'd0);
        check("arst_out_data", {64'b0, out_data}, 128'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", {127'b0, in_ready}, 128'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("arst_no_valid", {127'b0, seen}, 128'd0);
        applyStimulus(3'd0, 1'b0, 64'd10, 64'd10, 64'd100, 1'b1);
        checkOutput("post_reset", 0);

        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
